// File: rtl/spi_param_rx_pkg.sv
// spi_param_rx_pkg: state encoding shared by the SPI parameter receiver
package spi_param_rx_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ADDR = 2'd1;
  localparam state_t DATA = 2'd2;
  localparam state_t WAIT_END = 2'd3;
endpackage

// File: rtl/spi_param_rx_if.sv
// spi_param_rx_if: SPI pins (sclk, spi_load, spi_data) in, write strobe bus (wr_en, wr_addr, wr_data, frame_err, busy) out
interface spi_param_rx_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic sclk, spi_load, spi_data, wr_en, frame_err, busy;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  modport master (output sclk, spi_load, spi_data, input wr_en, wr_addr, wr_data, frame_err, busy);
  modport slave (input sclk, spi_load, spi_data, output wr_en, wr_addr, wr_data, frame_err, busy);
endinterface

// File: rtl/spi_param_rx_sync_edge.sv
// spi_param_rx_sync_edge: 2-FF synchroniser with registered level (q) and rise/fall pulses, all aligned; ports clk, rst, d -> q, rise, fall
module spi_param_rx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [1:0] s;
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
      q <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s <= {s[0], d};
      q <= s[1];
      rise <= s[1] & ~q;
      fall <= ~s[1] & q;
    end
  end
endmodule

// File: rtl/spi_param_rx.sv
// spi_param_rx: oversampled SPI slave turning address+data bursts on int_osc/reset into write strobes via bus; optional timeout with SPI_RX_TIMEOUT_EN
module spi_param_rx
  import spi_param_rx_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int MAX_WORDS = 512,
  parameter int AUTO_INC = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic int_osc,
  input logic reset,
  spi_param_rx_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_WORDS + 2);
  localparam int BIT_W = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
  state_t state;
  logic [BIT_W-1:0] bit_cnt, bit_nx, bit_after;
  logic [CNT_W-1:0] word_cnt, word_after;
  logic [ADDR_W-1:0] addr_sr, addr_reg, addr_nx;
  logic [DATA_W-1:0] data_sr, data_nx;
  logic [1:0] settle;
  logic sclk_rise, load_rise, load_fall, load_q, data_q, addr_done, word_done, wr_ok;
  logic sclk_unused_q, sclk_unused_fall, data_unused_rise, data_unused_fall;
`ifdef SPI_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] idle_cnt;
`endif
  spi_param_rx_sync_edge u_sclk (.clk(int_osc), .rst(reset), .d(bus.sclk), .q(sclk_unused_q), .rise(sclk_rise), .fall(sclk_unused_fall));
  spi_param_rx_sync_edge u_load (.clk(int_osc), .rst(reset), .d(bus.spi_load), .q(load_q), .rise(load_rise), .fall(load_fall));
  spi_param_rx_sync_edge u_data (.clk(int_osc), .rst(reset), .d(bus.spi_data), .q(data_q), .rise(data_unused_rise), .fall(data_unused_fall));
  assign bit_nx = bit_cnt + 1'b1;
  assign addr_nx = {addr_sr[ADDR_W-2:0], data_q};
  assign data_nx = {data_sr[DATA_W-2:0], data_q};
  assign addr_done = state == ADDR && sclk_rise && bit_nx == BIT_W'(ADDR_W);
  assign word_done = state == DATA && sclk_rise && bit_nx == BIT_W'(DATA_W);
  assign wr_ok = word_cnt < CNT_W'(MAX_WORDS);
  assign bit_after = (addr_done || word_done) ? '0 : sclk_rise ? bit_nx : bit_cnt;
  assign word_after = (word_done && word_cnt != CNT_W'(MAX_WORDS + 1)) ? word_cnt + 1'b1 : word_cnt;
  assign bus.busy = state == ADDR || state == DATA;
  always_ff @(posedge int_osc) begin
    if (reset) begin
      state <= WAIT_END;
      bit_cnt <= '0;
      word_cnt <= '0;
      addr_sr <= '0;
      data_sr <= '0;
      addr_reg <= '0;
      settle <= '0;
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.frame_err <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
      idle_cnt <= '0;
`endif
    end else begin
      bus.wr_en <= 1'b0;
      bus.frame_err <= 1'b0;
      settle <= settle + {1'b0, settle != 2'd3};
      case (state)
        IDLE: begin
          if (load_rise) begin
            state <= ADDR;
            bit_cnt <= '0;
            word_cnt <= '0;
`ifdef SPI_RX_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        WAIT_END: state <= (settle == 2'd3 && !load_q) ? IDLE : WAIT_END;
        default: begin
          bit_cnt <= bit_after;
          word_cnt <= word_after;
          if (sclk_rise && state == ADDR) addr_sr <= addr_nx;
          if (sclk_rise && state == DATA) data_sr <= data_nx;
          if (addr_done) begin
            addr_reg <= addr_nx;
            state <= DATA;
          end
          if (word_done && wr_ok) begin
            bus.wr_en <= 1'b1;
            bus.wr_addr <= addr_reg;
            bus.wr_data <= data_nx;
          end
          if (word_done && AUTO_INC != 0) addr_reg <= addr_reg + 1'b1;
`ifdef SPI_RX_TIMEOUT_EN
          idle_cnt <= sclk_rise ? '0 : idle_cnt + 1'b1;
          if (!sclk_rise && !load_fall && idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            bus.frame_err <= 1'b1;
            state <= WAIT_END;
          end
`endif
          if (load_fall) begin
            state <= IDLE;
            bus.frame_err <= bit_after != '0 || word_after > CNT_W'(MAX_WORDS);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_param_rx.sv
// tb_spi_param_rx: scoreboard bench driving two spi_param_rx configurations (auto-increment/512 words and fixed address/2 words)
module tb_spi_param_rx;
  logic int_osc = 1'b0;
  logic reset = 1'b1;
  logic sclk = 1'b0, spi_load = 1'b0, spi_data = 1'b0;
  int n_checks = 0, n_fail = 0, err_a = 0, err_b = 0;
  logic [15:0] q_a[$], q_b[$];
  time t_rise = 0, t_err = 0;
  spi_param_rx_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
  spi_param_rx_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();
  assign bus_a.sclk = sclk;
  assign bus_a.spi_load = spi_load;
  assign bus_a.spi_data = spi_data;
  assign bus_b.sclk = sclk;
  assign bus_b.spi_load = spi_load;
  assign bus_b.spi_data = spi_data;
  spi_param_rx #(.ADDR_W(8), .DATA_W(8), .MAX_WORDS(512), .AUTO_INC(1), .TIMEOUT_CYC(64)) dut_a (.int_osc(int_osc), .reset(reset), .bus(bus_a));
  spi_param_rx #(.ADDR_W(8), .DATA_W(8), .MAX_WORDS(2), .AUTO_INC(0), .TIMEOUT_CYC(64)) dut_b (.int_osc(int_osc), .reset(reset), .bus(bus_b));
  always #5 int_osc = ~int_osc;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge int_osc) begin
    if (bus_a.wr_en) begin
      if (q_a.size() == 0) check("a_extra_wr", 32'(bus_a.wr_en), 0);
      else check("a_wr", {bus_a.wr_addr, bus_a.wr_data}, q_a.pop_front());
      check("a_lat", 32'($time - t_rise), 40);
    end
    if (bus_a.frame_err) begin
      err_a++;
      t_err = $time;
    end
  end
  always @(negedge int_osc) begin
    if (bus_b.wr_en) begin
      if (q_b.size() == 0) check("b_extra_wr", 32'(bus_b.wr_en), 0);
      else check("b_wr", {bus_b.wr_addr, bus_b.wr_data}, q_b.pop_front());
      check("b_lat", 32'($time - t_rise), 40);
    end
    if (bus_b.frame_err) err_b++;
  end
  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_data = v[i];
      #40;
      t_rise = $time;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask
  task automatic frame(input logic [7:0] addr, input logic [31:0] w, input int n, input int extra);
    int ea, eb;
    ea = err_a;
    eb = err_b;
    for (int i = 0; i < n; i++) begin
      q_a.push_back({addr + 8'(i), w[31-8*i -: 8]});
      if (i < 2) q_b.push_back({addr, w[31-8*i -: 8]});
    end
    spi_load = 1'b1;
    #80;
    send_bits(addr, 8);
    check("busy_mid", 32'(bus_a.busy), 1);
    for (int i = 0; i < n; i++) send_bits(w[31-8*i -: 8], 8);
    send_bits(8'hFF, extra);
    spi_load = 1'b0;
    repeat (8) @(negedge int_osc);
    check("a_err", err_a - ea, 32'(extra != 0));
    check("b_err", err_b - eb, 32'(extra != 0 || n > 2));
    check("a_drain", q_a.size(), 0);
    check("b_drain", q_b.size(), 0);
    check("busy_end", 32'(bus_a.busy), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
  initial begin
    int ea, eb;
    repeat (3) @(negedge int_osc);
    check("rst_wr_en", 32'(bus_a.wr_en), 0);
    check("rst_wr_addr", 32'(bus_a.wr_addr), 0);
    check("rst_wr_data", 32'(bus_a.wr_data), 0);
    check("rst_err", 32'(bus_a.frame_err), 0);
    check("rst_busy", 32'(bus_a.busy), 0);
    reset = 1'b0;
    repeat (6) @(negedge int_osc);
    frame(8'h10, 32'hAA55_0000, 2, 0);
    frame(8'hFF, 32'h0102_0300, 3, 0);
    frame(8'h20, 32'h3C00_0000, 1, 3);
    frame(8'h05, 32'h1122_0000, 2, 0);
    frame(8'h40, 32'h0000_0000, 0, 0);
    ea = err_a;
    eb = err_b;
    spi_load = 1'b1;
    #160;
    spi_load = 1'b0;
    repeat (8) @(negedge int_osc);
    check("empty_err_a", err_a - ea, 0);
    check("empty_err_b", err_b - eb, 0);
    spi_load = 1'b1;
    #80;
    send_bits(8'hA0, 4);
    @(negedge int_osc);
    reset = 1'b1;
    repeat (2) @(negedge int_osc);
    check("midrst_busy", 32'(bus_a.busy), 0);
    check("midrst_wr_en", 32'(bus_b.wr_en), 0);
    reset = 1'b0;
    send_bits(8'h05, 4);
    send_bits(8'h99, 8);
    check("midrst_wait_busy", 32'(bus_a.busy), 0);
    spi_load = 1'b0;
    repeat (8) @(negedge int_osc);
    check("midrst_err_a", err_a - ea, 0);
    check("midrst_err_b", err_b - eb, 0);
    frame(8'h30, 32'h7E00_0000, 1, 0);
`ifdef SPI_RX_TIMEOUT_EN
    begin
      time t0;
      ea = err_a;
      spi_load = 1'b1;
      #80;
      send_bits(8'h50, 8);
      send_bits(8'h1F, 5);
      t0 = t_rise;
      repeat (80) @(negedge int_osc);
      check("to_err", err_a - ea, 1);
      check("to_time", 32'(t_err - t0), 680);
      check("to_busy", 32'(bus_a.busy), 0);
      send_bits(8'hFF, 8);
      spi_load = 1'b0;
      repeat (8) @(negedge int_osc);
      check("to_err_once", err_a - ea, 1);
      check("to_drain", q_a.size(), 0);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
